rsa_modexp_engine: RTL and testbench

Parametrised, multi-cycle RSA modular-exponentiation engine computing `result = data_in^exp mod n`, with `exp` selected from `e` (encrypt) or `d` (decrypt) by a per-request mode bit. It replaces the single-cycle combinational encrypt/decrypt pair with one shared sequential datapath. The datapath uses bit-serial interleaved modular multiplication under a start/busy/done handshake. Latency is fixed and data-independent for any given parameter set. It sits between the host-side register interface and the transmit framer.

---
 rtl/rsa_modexp_engine.sv | 136 +++++++++++++
 tb/tb_rsa_modexp_engine.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_engine.sv
// Sequential RSA modular exponentiation: LSB-first square-and-multiply over
// bit-serial interleaved modular multipliers, fixed data-independent latency.
module rsa_modexp_engine #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [EXP_WIDTH-1:0] d,
  input  logic [WIDTH-1:0]     n,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 error
);
  localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [JW-1:0]    J_TOP  = JW'(WIDTH - 1);
  localparam logic [IW-1:0]    I_LAST = IW'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD, MUL, FIN, ERR} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0]     m_q, n_q, r_q, b_q, acc1_q, acc2_q, p1, p2;
  logic [EXP_WIDTH-1:0] ex_q;
  logic [JW-1:0]        j_q;
  logic [IW-1:0]        i_q;
  logic                 req_bad;

  // One interleaved step: acc = 2*acc (+a) mod m, each stage reduced once
  // since every operand is already < m.
  function automatic logic [WIDTH-1:0] mstep(input logic [WIDTH-1:0] acc,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] m,
                                             input logic             bit_v);
    logic [WIDTH:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    if (bit_v) begin
      t = t + {1'b0, a};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end
    return t[WIDTH-1:0];
  endfunction

  assign req_bad = (n < WIDTH'(2)) || (data_in >= n);
  assign p1 = mstep(acc1_q, r_q, n_q, b_q[j_q]);
  assign p2 = mstep(acc2_q, b_q, n_q, b_q[j_q]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = req_bad ? ERR : LOAD;
      LOAD:    state_nx = MUL;
      MUL:     if (j_q == '0 && i_q == I_LAST) state_nx = FIN;
      FIN:     state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      error  <= 1'b0;
      m_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      b_q    <= '0;
      acc1_q <= '0;
      acc2_q <= '0;
      ex_q   <= '0;
      j_q    <= '0;
      i_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          m_q  <= data_in;
          n_q  <= n;
          ex_q <= mode ? d : e;
        end
        LOAD: begin
          r_q    <= ONE;
          b_q    <= m_q;
          acc1_q <= '0;
          acc2_q <= '0;
          j_q    <= J_TOP;
          i_q    <= '0;
        end
        MUL: begin
          if (j_q == '0) begin
            // Round end: both products always land, R only takes P1 on a set bit.
            b_q    <= p2;
            if (ex_q[0]) r_q <= p1;
            ex_q   <= ex_q >> 1;
            acc1_q <= '0;
            acc2_q <= '0;
            j_q    <= J_TOP;
            i_q    <= i_q + 1'b1;
          end else begin
            acc1_q <= p1;
            acc2_q <= p2;
            j_q    <= j_q - 1'b1;
          end
        end
        FIN: begin
          result <= r_q;
          error  <= 1'b0;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        ERR: begin
          result <= '0;
          error  <= 1'b1;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine: small 8-bit instance for the vector
// table and corner sequences, default-size instance for the 12-bit RSA pair.
module tb_rsa_modexp_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8/8 instance
  logic       start, mode, busy, done, error;
  logic [7:0] data_in, e, d, n, result;
  rsa_modexp_engine #(.WIDTH(8), .EXP_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .data_in(data_in),
    .e(e), .d(d), .n(n), .busy(busy), .done(done), .result(result), .error(error));

  // default-size instance
  logic         bstart, bmode, bbusy, bdone, berror;
  logic [127:0] bdata, bn, bresult;
  logic [63:0]  be, bd;
  rsa_modexp_engine dut_big (
    .clk(clk), .reset(reset), .start(bstart), .mode(bmode), .data_in(bdata),
    .e(be), .d(bd), .n(bn), .busy(bbusy), .done(bdone), .result(bresult), .error(berror));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drives a request for one cycle starting just after an active edge.
  task automatic issue(input logic md, input logic [7:0] di, input logic [7:0] ee,
                       input logic [7:0] dd, input logic [7:0] nn);
    mode = md; data_in = di; e = ee; d = dd; n = nn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
  endtask

  // Waits (bounded) for done, counting edges from the accept edge.
  task automatic wait_done(input bit big, input int exp_lat, input logic [127:0] exp_res,
                           input logic exp_err, input string nm);
    int got = 0;
    int busy_low = 0;
    for (int k = 1; k <= exp_lat + 20; k++) begin
      @(posedge clk); #1;
      if (big ? bdone : done) begin got = k; break; end
      if (!(big ? bbusy : busy)) busy_low++;
    end
    chk({nm, "_latency"}, got, exp_lat);
    chk({nm, "_busy_low"}, busy_low, 0);
    chk({nm, "_result"}, big ? bresult : {120'd0, result}, exp_res);
    chk({nm, "_error"}, big ? berror : error, exp_err);
    chk({nm, "_busy_at_done"}, big ? bbusy : busy, 1'b0);
  endtask

  typedef struct {
    logic       md;
    logic [7:0] di, ee, dd, nn, res;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vt[$];

  initial begin
    int got;
    int spurious;
    vt.push_back('{1'b0,   8'd9,  8'd7, 8'd103, 8'd143,  8'd48, 1'b0, 66});
    vt.push_back('{1'b1,  8'd48,  8'd7, 8'd103, 8'd143,   8'd9, 1'b0, 66});
    vt.push_back('{1'b0,   8'd0,  8'd7, 8'd103, 8'd143,   8'd0, 1'b0, 66});
    vt.push_back('{1'b0,   8'd9,  8'd0, 8'd103, 8'd143,   8'd1, 1'b0, 66});
    vt.push_back('{1'b0,   8'd2,  8'd7, 8'd103, 8'd143, 8'd128, 1'b0, 66});
    vt.push_back('{1'b1, 8'd142,  8'd7, 8'd103, 8'd143, 8'd142, 1'b0, 66});
    vt.push_back('{1'b0,   8'd1,  8'd7, 8'd103,   8'd2,   8'd1, 1'b0, 66});
    vt.push_back('{1'b0,   8'd9,  8'd7, 8'd103,   8'd1,   8'd0, 1'b1, 1});
    vt.push_back('{1'b0,   8'd0,  8'd7, 8'd103,   8'd0,   8'd0, 1'b1, 1});
    vt.push_back('{1'b0, 8'd150,  8'd7, 8'd103, 8'd143,   8'd0, 1'b1, 1});
    vt.push_back('{1'b0, 8'd143,  8'd7, 8'd103, 8'd143,   8'd0, 1'b1, 1});
    vt.push_back('{1'b0,   8'd9,  8'd7, 8'd103, 8'd143,  8'd48, 1'b0, 66});

    reset = 1'b1; start = 1'b0; mode = 1'b0; data_in = '0; e = '0; d = '0; n = '0;
    bstart = 1'b0; bmode = 1'b0; bdata = '0; bn = '0; be = '0; bd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'd0);
    chk("rst_error", error, 1'b0);
    @(posedge clk); #1;

    foreach (vt[i]) begin
      issue(vt[i].md, vt[i].di, vt[i].ee, vt[i].dd, vt[i].nn);
      wait_done(1'b0, vt[i].lat, {120'd0, vt[i].res}, vt[i].err, $sformatf("vec%0d", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), done, 1'b0);
      chk($sformatf("vec%0d_result_held", i), result, vt[i].res);
    end

    // Restarts while busy are dropped and latched operands are unaffected.
    issue(1'b0, 8'd9, 8'd7, 8'd103, 8'd143);
    got = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 10 || k == 40) begin
        mode = 1'b1; data_in = 8'd5; n = 8'd1; e = 8'd0; d = 8'd0; start = 1'b1;
      end else begin
        start = 1'b0;
        if (k == 20) begin data_in = 8'd77; n = 8'd200; e = 8'd3; end
      end
      @(posedge clk); #1;
      if (done) begin got = k; break; end
    end
    start = 1'b0;
    chk("ignore_latency", got, 66);
    chk("ignore_result", result, 8'd48);
    chk("ignore_error", error, 1'b0);

    // Start in the done cycle is accepted.
    issue(1'b0, 8'd2, 8'd7, 8'd103, 8'd143);
    wait_done(1'b0, 66, 128'd128, 1'b0, "b2b");

    // Mid-run reset: outputs clear at once, no done afterwards.
    @(posedge clk); #1;
    issue(1'b0, 8'd9, 8'd7, 8'd103, 8'd143);
    repeat (29) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_result", result, 8'd0);
    chk("midrst_error", error, 1'b0);
    chk("midrst_done", done, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    spurious = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (done || busy) spurious++;
    end
    chk("midrst_no_done", spurious, 0);
    chk("midrst_result_after", result, 8'd0);
    issue(1'b1, 8'd48, 8'd7, 8'd103, 8'd143);
    wait_done(1'b0, 66, 128'd9, 1'b0, "post_rst");

    // Default parameters: 12-bit RSA textbook pair.
    bmode = 1'b0; bdata = 128'd65; bn = 128'd3233; be = 64'd17; bd = 64'd2753; bstart = 1'b1;
    @(posedge clk); #1 bstart = 1'b0;
    chk("big_busy", bbusy, 1'b1);
    wait_done(1'b1, 8194, 128'd2790, 1'b0, "big_enc");
    bmode = 1'b1; bdata = 128'd2790; bstart = 1'b1;
    @(posedge clk); #1 bstart = 1'b0;
    wait_done(1'b1, 8194, 128'd65, 1'b0, "big_dec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
